// File: rtl/lock_reset_gen.sv
// Lock-qualified reset generator: synchronises and filters PLL LOCK, stretches reset once lock is
// stable, re-asserts it on lock loss or soft request, and keeps a saturating lock-loss counter.
module lock_reset_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILT   = 1024,
    parameter int RST_HOLD    = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LOCK_IN,
    input  logic       SOFT_RST,
    input  logic       LOSS_CLR,
    output logic       PRESETN,
    output logic       RST_OUT,
    output logic       READY,
    output logic [7:0] LOSS_CNT
);
    localparam int CNT_MAX = (LOCK_FILT > RST_HOLD) ? LOCK_FILT : RST_HOLD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] FILT_END = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        STRETCH   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             loss_q, loss_d;
    logic                   presetn_q, rst_out_q, ready_q;
    logic                   lock_s;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) state_d = FILTER;
            end
            FILTER: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == FILT_END) begin
                    state_d = STRETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STRETCH: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_END) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                // Lock loss outranks a same-cycle soft request.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end else if (SOFT_RST) begin
                    state_d = STRETCH;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        if (LOSS_CLR) loss_d = '0;
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q    <= '0;
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            loss_q    <= '0;
            presetn_q <= 1'b0;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], LOCK_IN};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            loss_q    <= loss_d;
            presetn_q <= (state_d == RUN);
            rst_out_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
        end
    end

    assign PRESETN  = presetn_q;
    assign RST_OUT  = rst_out_q;
    assign READY    = ready_q;
    assign LOSS_CNT = loss_q;

endmodule

// File: tb/tb_lock_reset_gen.sv
// Bench for lock_reset_gen with LOCK_FILT=8, RST_HOLD=4, SYNC_STAGES=2: expected PRESETN edge
// numbers and LOSS_CNT values are queued when stimulus is applied and checked when PRESETN moves.
`timescale 1ns/1ps
module tb_lock_reset_gen;
    localparam int QUAL = 14;

    logic       CLK = 1'b0;
    logic       RESET, LOCK_IN, SOFT_RST, LOSS_CLR;
    logic       PRESETN, RST_OUT, READY;
    logic [7:0] LOSS_CNT;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int model_loss = 0;

    typedef struct {
        int         edge_no;
        logic [7:0] loss;
    } exp_t;
    exp_t sb_q[$];

    lock_reset_gen #(.SYNC_STAGES(2), .LOCK_FILT(8), .RST_HOLD(4)) dut (
        .CLK(CLK), .RESET(RESET), .LOCK_IN(LOCK_IN), .SOFT_RST(SOFT_RST), .LOSS_CLR(LOSS_CLR),
        .PRESETN(PRESETN), .RST_OUT(RST_OUT), .READY(READY), .LOSS_CNT(LOSS_CNT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) edge_n <= edge_n + 1;

    task automatic push_exp(input int ed, input logic [7:0] ls);
        exp_t e;
        e.edge_no = ed;
        e.loss    = ls;
        sb_q.push_back(e);
    endtask

    // Returns the edge number at which PRESETN first reads lvl, or -1 when the budget expires.
    task automatic wait_presetn(input logic lvl, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            @(posedge CLK);
            #1;
            if (PRESETN === lvl) at = edge_n;
        end
    endtask

    task automatic test_reset();
        int   at;
        exp_t e;
        RESET = 1'b1; LOCK_IN = 1'b0; SOFT_RST = 1'b0; LOSS_CLR = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks += 4;
        if (PRESETN !== 1'b0) begin failures++; $display("FAIL reset_presetn got=%b exp=0", PRESETN); end
        if (RST_OUT !== 1'b1) begin failures++; $display("FAIL reset_rst_out got=%b exp=1", RST_OUT); end
        if (READY !== 1'b0)   begin failures++; $display("FAIL reset_ready got=%b exp=0", READY); end
        if (LOSS_CNT !== 8'd0) begin failures++; $display("FAIL reset_loss got=%0d exp=0", LOSS_CNT); end
        @(negedge CLK);
        RESET = 1'b0; LOCK_IN = 1'b1;
        push_exp(edge_n + 1 + QUAL, 8'd0);
        at = -1;
        for (int i = 0; i < 40 && at < 0; i++) begin
            @(posedge CLK);
            #1;
            checks += 2;
            if (RST_OUT !== ~PRESETN) begin failures++; $display("FAIL powerup_rst_out got=%b exp=%b", RST_OUT, ~PRESETN); end
            if (READY !== PRESETN) begin failures++; $display("FAIL powerup_ready got=%b exp=%b", READY, PRESETN); end
            if (PRESETN === 1'b1) at = edge_n;
        end
        e = sb_q.pop_front();
        checks += 2;
        if (at !== e.edge_no) begin failures++; $display("FAIL powerup_rise_edge got=%0d exp=%0d", at, e.edge_no); end
        if (LOSS_CNT !== e.loss) begin failures++; $display("FAIL powerup_loss got=%0d exp=%0d", LOSS_CNT, e.loss); end
    endtask

    task automatic test_filter_abort();
        int   at;
        exp_t e;
        RESET = 1'b1; LOCK_IN = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        LOCK_IN = 1'b1;
        repeat (5) @(negedge CLK);
        LOCK_IN = 1'b0;
        @(negedge CLK);
        LOCK_IN = 1'b1;
        push_exp(edge_n + 1 + QUAL, 8'd0);
        wait_presetn(1'b1, 40, at);
        e = sb_q.pop_front();
        checks += 2;
        if (at !== e.edge_no) begin failures++; $display("FAIL abort_rise_edge got=%0d exp=%0d", at, e.edge_no); end
        if (LOSS_CNT !== e.loss) begin failures++; $display("FAIL abort_loss got=%0d exp=%0d", LOSS_CNT, e.loss); end
    endtask

    task automatic test_lock_loss();
        int   at;
        exp_t e;
        @(negedge CLK);
        LOCK_IN = 1'b0;
        push_exp(edge_n + 1 + 2, 8'd1);
        wait_presetn(1'b0, 10, at);
        e = sb_q.pop_front();
        checks += 3;
        if (at !== e.edge_no) begin failures++; $display("FAIL loss_fall_edge got=%0d exp=%0d", at, e.edge_no); end
        if (LOSS_CNT !== e.loss) begin failures++; $display("FAIL loss_count got=%0d exp=%0d", LOSS_CNT, e.loss); end
        if (READY !== 1'b0) begin failures++; $display("FAIL loss_ready got=%b exp=0", READY); end
        @(negedge CLK);
        LOCK_IN = 1'b1;
        push_exp(edge_n + 1 + QUAL, 8'd1);
        wait_presetn(1'b1, 40, at);
        e = sb_q.pop_front();
        checks += 2;
        if (at !== e.edge_no) begin failures++; $display("FAIL loss_requal_edge got=%0d exp=%0d", at, e.edge_no); end
        if (LOSS_CNT !== e.loss) begin failures++; $display("FAIL loss_requal_count got=%0d exp=%0d", LOSS_CNT, e.loss); end
    endtask

    task automatic test_soft_reset();
        int   at;
        exp_t e;
        @(negedge CLK);
        SOFT_RST = 1'b1;
        push_exp(edge_n + 1 + 4, 8'd1);
        @(negedge CLK);
        SOFT_RST = 1'b0;
        checks++;
        if (PRESETN !== 1'b0) begin failures++; $display("FAIL soft_low got=%b exp=0", PRESETN); end
        wait_presetn(1'b1, 20, at);
        e = sb_q.pop_front();
        checks += 2;
        if (at !== e.edge_no) begin failures++; $display("FAIL soft_rise_edge got=%0d exp=%0d", at, e.edge_no); end
        if (LOSS_CNT !== e.loss) begin failures++; $display("FAIL soft_loss got=%0d exp=%0d", LOSS_CNT, e.loss); end
        // Soft request during FILTER must not shorten or restart qualification.
        @(negedge CLK);
        LOCK_IN = 1'b0;
        wait_presetn(1'b0, 10, at);
        checks++;
        if (at < 0) begin failures++; $display("FAIL soft_drop_timeout got=%0d exp=fall", at); end
        @(negedge CLK);
        LOCK_IN = 1'b1;
        push_exp(edge_n + 1 + QUAL, 8'd2);
        repeat (5) @(negedge CLK);
        SOFT_RST = 1'b1;
        @(negedge CLK);
        SOFT_RST = 1'b0;
        wait_presetn(1'b1, 40, at);
        e = sb_q.pop_front();
        checks += 2;
        if (at !== e.edge_no) begin failures++; $display("FAIL soft_filter_edge got=%0d exp=%0d", at, e.edge_no); end
        if (LOSS_CNT !== e.loss) begin failures++; $display("FAIL soft_filter_loss got=%0d exp=%0d", LOSS_CNT, e.loss); end
    endtask

    task automatic test_counter_edges();
        int   at;
        exp_t e;
        // Clear coincident with an increment.
        @(negedge CLK);
        LOCK_IN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        LOSS_CLR = 1'b1;
        @(posedge CLK);
        #1;
        checks += 2;
        if (PRESETN !== 1'b0) begin failures++; $display("FAIL clr_inc_presetn got=%b exp=0", PRESETN); end
        if (LOSS_CNT !== 8'd0) begin failures++; $display("FAIL clr_inc_loss got=%0d exp=0", LOSS_CNT); end
        @(negedge CLK);
        LOSS_CLR = 1'b0; LOCK_IN = 1'b1;
        push_exp(edge_n + 1 + QUAL, 8'd0);
        wait_presetn(1'b1, 40, at);
        e = sb_q.pop_front();
        checks++;
        if (at !== e.edge_no) begin failures++; $display("FAIL clr_requal_edge got=%0d exp=%0d", at, e.edge_no); end
        // Soft request coincident with lock loss.
        @(negedge CLK);
        LOCK_IN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        SOFT_RST = 1'b1;
        @(posedge CLK);
        #1;
        checks += 2;
        if (PRESETN !== 1'b0) begin failures++; $display("FAIL soft_loss_presetn got=%b exp=0", PRESETN); end
        if (LOSS_CNT !== 8'd1) begin failures++; $display("FAIL soft_loss_count got=%0d exp=1", LOSS_CNT); end
        @(negedge CLK);
        SOFT_RST = 1'b0; LOCK_IN = 1'b1;
        push_exp(edge_n + 1 + QUAL, 8'd1);
        wait_presetn(1'b1, 40, at);
        e = sb_q.pop_front();
        checks += 2;
        if (at !== e.edge_no) begin failures++; $display("FAIL soft_loss_requal got=%0d exp=%0d", at, e.edge_no); end
        if (LOSS_CNT !== e.loss) begin failures++; $display("FAIL soft_loss_requal_cnt got=%0d exp=%0d", LOSS_CNT, e.loss); end
        // Plain clear, then saturation over 256 losses.
        @(negedge CLK);
        LOSS_CLR = 1'b1;
        @(negedge CLK);
        LOSS_CLR = 1'b0;
        checks++;
        if (LOSS_CNT !== 8'd0) begin failures++; $display("FAIL clr_plain got=%0d exp=0", LOSS_CNT); end
        model_loss = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            LOCK_IN = 1'b0;
            model_loss = (model_loss >= 255) ? 255 : model_loss + 1;
            push_exp(edge_n + 1 + 2, 8'(model_loss));
            wait_presetn(1'b0, 10, at);
            e = sb_q.pop_front();
            checks += 2;
            if (at !== e.edge_no) begin failures++; $display("FAIL sat_fall_edge[%0d] got=%0d exp=%0d", i, at, e.edge_no); end
            if (LOSS_CNT !== e.loss) begin failures++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, LOSS_CNT, e.loss); end
            @(negedge CLK);
            LOCK_IN = 1'b1;
            wait_presetn(1'b1, 40, at);
            checks++;
            if (at < 0) begin failures++; $display("FAIL sat_requal_timeout[%0d] got=%0d exp=rise", i, at); end
        end
        checks++;
        if (LOSS_CNT !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d exp=255", LOSS_CNT); end
    endtask

    task automatic test_async_reset();
        int   at;
        exp_t e;
        @(negedge CLK);
        LOCK_IN = 1'b0;
        wait_presetn(1'b0, 10, at);
        checks++;
        if (at < 0) begin failures++; $display("FAIL arst_drop_timeout got=%0d exp=fall", at); end
        @(negedge CLK);
        LOCK_IN = 1'b1;
        repeat (12) @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        checks += 4;
        if (PRESETN !== 1'b0) begin failures++; $display("FAIL arst_presetn got=%b exp=0", PRESETN); end
        if (RST_OUT !== 1'b1) begin failures++; $display("FAIL arst_rst_out got=%b exp=1", RST_OUT); end
        if (READY !== 1'b0)   begin failures++; $display("FAIL arst_ready got=%b exp=0", READY); end
        if (LOSS_CNT !== 8'd0) begin failures++; $display("FAIL arst_loss got=%0d exp=0", LOSS_CNT); end
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        push_exp(edge_n + 1 + QUAL, 8'd0);
        wait_presetn(1'b1, 40, at);
        e = sb_q.pop_front();
        checks += 2;
        if (at !== e.edge_no) begin failures++; $display("FAIL arst_requal_edge got=%0d exp=%0d", at, e.edge_no); end
        if (LOSS_CNT !== e.loss) begin failures++; $display("FAIL arst_requal_loss got=%0d exp=%0d", LOSS_CNT, e.loss); end
        // Reset taken from RUN drops PRESETN without waiting for an edge.
        #2;
        RESET = 1'b1;
        #1;
        checks += 2;
        if (PRESETN !== 1'b0) begin failures++; $display("FAIL arst_run_presetn got=%b exp=0", PRESETN); end
        if (READY !== 1'b0)   begin failures++; $display("FAIL arst_run_ready got=%b exp=0", READY); end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        test_reset();
        test_filter_abort();
        test_lock_loss();
        test_soft_reset();
        test_counter_edges();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
